bus_sequencer: RTL and testbench
================================

Name: bus_sequencer

Overview:
- Time-multiplexes the shared 17-bit memory/IO bus between the 6502 CPU and the MCU (SPI bridge) in fixed alternating slots.
- Drives addr_o into the address decoder and consumes the decoder's select/attribute outputs (ram_en, is_readonly, is_mirrored, io_en).
- From those it generates RAM OE/WE, the IO chip strobe, the CPU phi2 clock, the video-shadow write pulse and the MCU acknowledge.
- Sits directly upstream of the address decoder and downstream of the CPU pins and the SPI bridge.

Parameters:
STROBE_CLKS, 2, clocks in each STROBE state (legal range 1..15). Bus period = 2*(STROBE_CLKS+2) clocks.

Ports:
clk_i  in  1  system clock
reset_i  in  1  asynchronous, active-high reset
cpu_addr_i  in  16  CPU address bus
cpu_we_i  in  1  CPU write (1 = write, inverted R/W)
mcu_req_i  in  1  MCU access request (level)
mcu_addr_i  in  17  MCU target address
mcu_we_i  in  1  MCU write (1 = write)
ram_en_i  in  1  from decoder: addr_o hits RAM/ROM/VRAM
is_readonly_i  in  1  from decoder: ROM region
is_mirrored_i  in  1  from decoder: VRAM region
io_en_i  in  1  from decoder: PIA/VIA/CRTC region
addr_o  out  17  registered bus address to decoder/RAM
cpu_sel_o  out  1  1 = CPU slot owns the bus (data-path mux select)
cpu_phi2_o  out  1  CPU phi2 clock
ram_oe_o  out  1  RAM output enable
ram_we_o  out  1  RAM write enable
io_strobe_o  out  1  IO chip-select strobe
vram_wr_o  out  1  1-clk pulse: write to mirrored VRAM completed
mcu_ack_o  out  1  1-clk pulse: MCU access completed, read data valid this edge

Behaviour:
- Reset: asynchronous, active-high on reset_i, clock clk_i. While reset_i is high: state=CPU_ADDR, strobe counter=0, addr_o=0. All outputs are 0 except cpu_sel_o=1, including cpu_phi2_o.
- States: CPU_ADDR(1) -> CPU_STROBE(STROBE_CLKS) -> CPU_HOLD(1) -> MCU_ADDR(1) -> MCU_STROBE(STROBE_CLKS) -> MCU_HOLD(1) -> CPU_ADDR.
- The sequence is fixed and free-running; the period never stretches whether or not the MCU slot is used.
- The strobe counter counts 0..STROBE_CLKS-1 in STROBE states and clears on exit.
- CPU address latch: on the clock edge entering CPU_ADDR, addr_o <= {1'b0, cpu_addr_i} and cpu_we_i is latched.
- MCU address latch: on the edge entering MCU_ADDR, mcu_req_i is sampled.
  - If high: slot is active; addr_o <= mcu_addr_i; mcu_we_i is latched.
  - If low: slot is idle; addr_o holds its value and no strobes are issued.
- cpu_sel_o=1 in CPU_* states, 0 in MCU_* states.
- cpu_phi2_o=1 in CPU_STROBE and CPU_HOLD, 0 otherwise.
- Strobes are asserted only in STROBE states of an active slot. They are combinational from registered state, latched we and decoder inputs:
  - ram_oe_o = ram_en_i & !we.
  - ram_we_o = ram_en_i & we & !(is_readonly_i & cpu slot). CPU writes to ROM are suppressed; MCU writes to ROM are allowed (ROM load).
  - io_strobe_o = io_en_i & cpu slot. MCU accesses to IO issue no strobe but are still acknowledged.
- vram_wr_o pulses for 1 clk in the HOLD state following a strobe phase in which ram_we_o was asserted and is_mirrored_i=1. This applies to both slots.
- mcu_ack_o pulses for 1 clk in MCU_HOLD of an active slot only.
  - The requester must drop mcu_req_i within the cycle after ack; a request still high at the next MCU_ADDR entry is serviced again.
- addr_o is stable from the ADDR state through the HOLD state of each slot; decoder outputs are treated as settled by the first STROBE clock.
- Reset asserted mid-slot: all strobes and phi2 drop immediately and no ack is issued. The sequence restarts at CPU_ADDR after release.
- Latency: MCU request to ack is at most one period plus STROBE_CLKS+2 clocks (worst case: request arrives just after MCU_ADDR sampling).

Test Plan:
1. Reset release, STROBE_CLKS=2, no MCU requests -> period 8 clk; cpu_phi2_o high in cycles 1-3 of each period; cpu_sel_o high in cycles 0-3; no strobes in cycles 4-7.
2. CPU read cpu_addr_i=16'h0123 (RAM) -> addr_o=17'h00123 in cycles 0-3; ram_oe_o high in cycles 1-2; ram_we_o, io_strobe_o and vram_wr_o stay 0.
3. CPU write to 16'h8010 (VRAM) -> ram_we_o high in cycles 1-2; vram_wr_o high in cycle 3 only. CPU write to 16'hC000 (ROM) -> ram_we_o stays 0.
4. MCU write mcu_addr_i=17'h0C000 with mcu_req_i held high -> ram_we_o high in MCU_STROBE; mcu_ack_o high one clk in MCU_HOLD. If req is dropped after ack, the next MCU slot is idle.
5. CPU read 16'hE812 (PIA1) -> io_strobe_o high in cycles 1-2. MCU read 17'h0E812 -> io_strobe_o stays 0 and mcu_ack_o still pulses.
6. Assert reset_i during MCU_STROBE of an active write -> ram_we_o drops asynchronously with no ack. After release: CPU_ADDR, addr_o=0, MCU request serviced in the next MCU slot.

Source files
------------

// File: rtl/bus_sequencer.sv
// Shared-bus slot sequencer: alternates fixed CPU and MCU slots on the 17-bit
// memory/IO bus, latches each slot's address and direction, and turns the
// decoder's select/attribute flags into RAM, IO, phi2, VRAM-shadow and ack strobes.
module bus_sequencer #(
    parameter int unsigned STROBE_CLKS = 2  // clocks per STROBE state, 1..15
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [15:0] cpu_addr_i,
    input  logic        cpu_we_i,
    input  logic        mcu_req_i,
    input  logic [16:0] mcu_addr_i,
    input  logic        mcu_we_i,
    input  logic        ram_en_i,
    input  logic        is_readonly_i,
    input  logic        is_mirrored_i,
    input  logic        io_en_i,
    output logic [16:0] addr_o,
    output logic        cpu_sel_o,
    output logic        cpu_phi2_o,
    output logic        ram_oe_o,
    output logic        ram_we_o,
    output logic        io_strobe_o,
    output logic        vram_wr_o,
    output logic        mcu_ack_o
);

    localparam logic [2:0] StCpuAddr   = 3'd0;
    localparam logic [2:0] StCpuStrobe = 3'd1;
    localparam logic [2:0] StCpuHold   = 3'd2;
    localparam logic [2:0] StMcuAddr   = 3'd3;
    localparam logic [2:0] StMcuStrobe = 3'd4;
    localparam logic [2:0] StMcuHold   = 3'd5;

    localparam logic [3:0] CntLast = 4'(STROBE_CLKS - 1);

    logic [2:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [16:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic        active_q, active_d;       // MCU slot carries a request
    logic        vram_seen_q, vram_seen_d; // mirrored write seen in this strobe phase

    logic cpu_slot;
    logic strobe_active;

    // Next-state: fixed free-running slot sequence plus per-slot address latching
    always_comb begin
        state_d     = state_q;
        cnt_d       = 4'd0;
        addr_d      = addr_q;
        we_d        = we_q;
        active_d    = active_q;
        vram_seen_d = 1'b0;
        unique case (state_q)
            StCpuAddr: state_d = StCpuStrobe;
            StCpuStrobe: begin
                vram_seen_d = vram_seen_q | (ram_we_o & is_mirrored_i);
                if (cnt_q == CntLast) begin
                    state_d = StCpuHold;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StCpuHold: begin
                // Entering MCU_ADDR: sample the request; an idle slot keeps addr_o
                state_d  = StMcuAddr;
                active_d = mcu_req_i;
                if (mcu_req_i) begin
                    addr_d = mcu_addr_i;
                    we_d   = mcu_we_i;
                end
            end
            StMcuAddr: state_d = StMcuStrobe;
            StMcuStrobe: begin
                vram_seen_d = vram_seen_q | (ram_we_o & is_mirrored_i);
                if (cnt_q == CntLast) begin
                    state_d = StMcuHold;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StMcuHold: begin
                state_d = StCpuAddr;
                addr_d  = {1'b0, cpu_addr_i};
                we_d    = cpu_we_i;
            end
            default: state_d = StCpuAddr;
        endcase
        // The flag must survive into HOLD where the pulse is issued
        if (state_q == StCpuHold || state_q == StMcuHold) begin
            vram_seen_d = 1'b0;
        end
    end

    // Sequencer state registers with asynchronous reset
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StCpuAddr;
            cnt_q       <= 4'd0;
            addr_q      <= 17'd0;
            we_q        <= 1'b0;
            active_q    <= 1'b0;
            vram_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            active_q    <= active_d;
            vram_seen_q <= vram_seen_d;
        end
    end

    // Outputs decoded from registered state, latched direction and decoder flags
    always_comb begin
        cpu_slot      = (state_q == StCpuAddr) || (state_q == StCpuStrobe) ||
                        (state_q == StCpuHold);
        strobe_active = (state_q == StCpuStrobe) || ((state_q == StMcuStrobe) && active_q);
        addr_o        = addr_q;
        cpu_sel_o     = cpu_slot;
        cpu_phi2_o    = (state_q == StCpuStrobe) || (state_q == StCpuHold);
        ram_oe_o      = strobe_active & ram_en_i & ~we_q;
        // CPU writes to ROM are dropped; the MCU may write ROM to load it
        ram_we_o      = strobe_active & ram_en_i & we_q & ~(is_readonly_i & cpu_slot);
        io_strobe_o   = strobe_active & io_en_i & cpu_slot;
        vram_wr_o     = vram_seen_q &
                        ((state_q == StCpuHold) || ((state_q == StMcuHold) && active_q));
        mcu_ack_o     = (state_q == StMcuHold) && active_q;
    end

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed bench for bus_sequencer with STROBE_CLKS=2 (8-clock period).
// A small address-decoder model closes the loop from addr_o back to the
// decoder inputs; expected per-cycle waveforms are 8-bit masks (bit n = cycle n).
module tb_bus_sequencer;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [15:0] cpu_addr_i;
    logic        cpu_we_i;
    logic        mcu_req_i;
    logic [16:0] mcu_addr_i;
    logic        mcu_we_i;
    logic        ram_en_i, is_readonly_i, is_mirrored_i, io_en_i;
    logic [16:0] addr_o;
    logic        cpu_sel_o, cpu_phi2_o, ram_oe_o, ram_we_o, io_strobe_o, vram_wr_o, mcu_ack_o;

    int checks = 0;
    int errors = 0;

    logic [7:0] p_sel, p_phi2, p_oe, p_we, p_io, p_vram, p_ack;

    always #5 clk_i = ~clk_i;

    bus_sequencer #(.STROBE_CLKS(2)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .cpu_addr_i    (cpu_addr_i),
        .cpu_we_i      (cpu_we_i),
        .mcu_req_i     (mcu_req_i),
        .mcu_addr_i    (mcu_addr_i),
        .mcu_we_i      (mcu_we_i),
        .ram_en_i      (ram_en_i),
        .is_readonly_i (is_readonly_i),
        .is_mirrored_i (is_mirrored_i),
        .io_en_i       (io_en_i),
        .addr_o        (addr_o),
        .cpu_sel_o     (cpu_sel_o),
        .cpu_phi2_o    (cpu_phi2_o),
        .ram_oe_o      (ram_oe_o),
        .ram_we_o      (ram_we_o),
        .io_strobe_o   (io_strobe_o),
        .vram_wr_o     (vram_wr_o),
        .mcu_ack_o     (mcu_ack_o)
    );

    // Decoder model: RAM, 8000-8FFF VRAM, C000-E7FF/F000-FFFF ROM, E800-EFFF IO
    always_comb begin
        ram_en_i      = 1'b0;
        is_readonly_i = 1'b0;
        is_mirrored_i = 1'b0;
        io_en_i       = 1'b0;
        if (addr_o[16] || addr_o[15:0] < 16'h8000) begin
            ram_en_i = 1'b1;
        end else if (addr_o[15:0] < 16'h9000) begin
            ram_en_i      = 1'b1;
            is_mirrored_i = 1'b1;
        end else if (addr_o[15:0] < 16'hC000) begin
            ram_en_i = 1'b1;
        end else if (addr_o[15:0] >= 16'hE800 && addr_o[15:0] < 16'hF000) begin
            io_en_i = 1'b1;
        end else begin
            ram_en_i      = 1'b1;
            is_readonly_i = 1'b1;
        end
    end

    typedef struct {
        string       name;
        logic [15:0] cpu_addr;
        logic        cpu_we;
        logic        mcu_req;
        logic [16:0] mcu_addr;
        logic        mcu_we;
        logic [16:0] ea_cpu;
        logic [16:0] ea_mcu;
        logic [7:0]  oe, we, io, vram, ack;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Capture one full period; in_place means cycle 0 is already present
    task automatic run_period(input bit in_place, input logic [16:0] ea_cpu,
                              input logic [16:0] ea_mcu, input string name);
        logic [16:0] a_cpu, a_mcu;
        a_cpu = ea_cpu;
        a_mcu = ea_mcu;
        for (int c = 0; c < 8; c++) begin
            if (!(c == 0 && in_place)) begin
                @(posedge clk_i);
                #1;
            end
            p_sel[c]  = cpu_sel_o;
            p_phi2[c] = cpu_phi2_o;
            p_oe[c]   = ram_oe_o;
            p_we[c]   = ram_we_o;
            p_io[c]   = io_strobe_o;
            p_vram[c] = vram_wr_o;
            p_ack[c]  = mcu_ack_o;
            if (c < 4 && addr_o !== ea_cpu && a_cpu === ea_cpu) a_cpu = addr_o;
            if (c >= 4 && addr_o !== ea_mcu && a_mcu === ea_mcu) a_mcu = addr_o;
        end
        chk({name, " sel"}, 32'(p_sel), 32'h0F);
        chk({name, " phi2"}, 32'(p_phi2), 32'h0E);
        chk({name, " addr_cpu"}, 32'(a_cpu), 32'(ea_cpu));
        chk({name, " addr_mcu"}, 32'(a_mcu), 32'(ea_mcu));
    endtask

    task automatic chk_strobes(input string name, input logic [7:0] oe, input logic [7:0] we,
                               input logic [7:0] io, input logic [7:0] vram,
                               input logic [7:0] ack);
        chk({name, " oe"}, 32'(p_oe), 32'(oe));
        chk({name, " we"}, 32'(p_we), 32'(we));
        chk({name, " io"}, 32'(p_io), 32'(io));
        chk({name, " vram"}, 32'(p_vram), 32'(vram));
        chk({name, " ack"}, 32'(p_ack), 32'(ack));
    endtask

    initial begin
        logic ack_seen;
        //          name        cpu_a    we  req mcu_a      mwe ea_cpu     ea_mcu     oe     we     io     vram   ack
        vecs[0] = '{"rd_ram",   16'h0123, 0, 0, 17'h00000, 0, 17'h00123, 17'h00123, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[1] = '{"wr_vram",  16'h8010, 1, 0, 17'h00000, 0, 17'h08010, 17'h08010, 8'h00, 8'h06, 8'h00, 8'h08, 8'h00};
        vecs[2] = '{"wr_rom",   16'hC000, 1, 0, 17'h00000, 0, 17'h0C000, 17'h0C000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[3] = '{"mcu_rom1", 16'h0000, 0, 1, 17'h0C000, 1, 17'h00000, 17'h0C000, 8'h06, 8'h60, 8'h00, 8'h00, 8'h80};
        vecs[4] = '{"mcu_rom2", 16'h0000, 0, 1, 17'h0C000, 1, 17'h00000, 17'h0C000, 8'h06, 8'h60, 8'h00, 8'h00, 8'h80};
        vecs[5] = '{"mcu_idle", 16'h0123, 0, 0, 17'h0C000, 1, 17'h00123, 17'h00123, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[6] = '{"io_pia",   16'hE812, 0, 1, 17'h0E812, 0, 17'h0E812, 17'h0E812, 8'h00, 8'h00, 8'h06, 8'h00, 8'h80};
        vecs[7] = '{"mcu_vram", 16'h1000, 0, 1, 17'h08020, 1, 17'h01000, 17'h08020, 8'h06, 8'h60, 8'h00, 8'h80, 8'h80};
        vecs[8] = '{"mcu_hi",   16'h2000, 1, 1, 17'h10005, 0, 17'h02000, 17'h10005, 8'h60, 8'h06, 8'h00, 8'h00, 8'h80};

        reset_i    = 1'b1;
        cpu_addr_i = 16'h0000;
        cpu_we_i   = 1'b0;
        mcu_req_i  = 1'b0;
        mcu_addr_i = 17'h00000;
        mcu_we_i   = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst addr", 32'(addr_o), 32'h0);
        chk("rst sel", 32'(cpu_sel_o), 32'h1);
        chk("rst phi2", 32'(cpu_phi2_o), 32'h0);
        chk("rst strobes", {28'h0, ram_oe_o, ram_we_o, io_strobe_o, vram_wr_o}, 32'h0);
        chk("rst ack", 32'(mcu_ack_o), 32'h0);

        // First period after release: addr 0 read, MCU slot idle
        @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        run_period(1'b1, 17'h00000, 17'h00000, "post_rst");
        chk_strobes("post_rst", 8'h06, 8'h00, 8'h00, 8'h00, 8'h00);

        for (int i = 0; i < 9; i++) begin
            cpu_addr_i = vecs[i].cpu_addr;
            cpu_we_i   = vecs[i].cpu_we;
            mcu_req_i  = vecs[i].mcu_req;
            mcu_addr_i = vecs[i].mcu_addr;
            mcu_we_i   = vecs[i].mcu_we;
            run_period(1'b0, vecs[i].ea_cpu, vecs[i].ea_mcu, vecs[i].name);
            chk_strobes(vecs[i].name, vecs[i].oe, vecs[i].we, vecs[i].io, vecs[i].vram,
                        vecs[i].ack);
        end

        // Reset in the middle of an active MCU write strobe
        cpu_addr_i = 16'h0123;
        cpu_we_i   = 1'b0;
        mcu_req_i  = 1'b1;
        mcu_addr_i = 17'h0C000;
        mcu_we_i   = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk_i);
            #1;
        end
        chk("midrst pre we", 32'(ram_we_o), 32'h1);
        #2;
        reset_i = 1'b1;
        #1;
        chk("midrst we", 32'(ram_we_o), 32'h0);
        chk("midrst addr", 32'(addr_o), 32'h0);
        chk("midrst sel", 32'(cpu_sel_o), 32'h1);
        ack_seen = mcu_ack_o;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk_i);
            #1;
            ack_seen = ack_seen | mcu_ack_o | cpu_phi2_o;
        end
        chk("midrst no ack", 32'(ack_seen), 32'h0);
        @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        run_period(1'b1, 17'h00000, 17'h0C000, "rst_resume");
        chk_strobes("rst_resume", 8'h06, 8'h60, 8'h00, 8'h00, 8'h80);
        mcu_req_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
